// File: rtl/debounced_hex_counter_if.sv
// debounced_hex_counter_if: button inputs, enable and counter outputs of the debounced hex counter
interface debounced_hex_counter_if;
  logic btn_up;
  logic btn_down;
  logic btn_clr;
  logic en;
  logic [3:0] count;
  logic step;
  logic wrap;
  modport master (output btn_up, btn_down, btn_clr, en, input count, step, wrap);
  modport slave (input btn_up, btn_down, btn_clr, en, output count, step, wrap);
endinterface

// File: rtl/debounced_hex_counter.sv
// debounced_hex_counter: three debounced buttons driving a modulo-16 up/down/clear counter
module debounced_hex_counter #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit WRAP = 1'b1
) (
  input logic clk,
  input logic rst_n,
  debounced_hex_counter_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, REL_WAIT} state_e;
  logic [2:0] raw;
  logic [2:0] pulse;
  logic [3:0] count_q, count_d;
  logic step_q, step_d, wrap_q, wrap_d;
  logic up_ok, dn_ok;
  assign raw = {bus.btn_clr, bus.btn_down, bus.btn_up};
  for (genvar i = 0; i < 3; i++) begin : g_btn
    logic [1:0] sync_q;
    state_e st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic pulse_q, pulse_d;
    logic s;
    assign s = sync_q[1];
    always_ff @(posedge clk)
      if (!rst_n) begin
        sync_q <= '0;
        st_q <= IDLE;
        cnt_q <= '0;
        pulse_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[0], raw[i]};
        st_q <= st_d;
        cnt_q <= cnt_d;
        pulse_q <= pulse_d;
      end
    // counter is cleared on every state change so it can never wrap
    always_comb begin
      st_d = st_q;
      cnt_d = cnt_q;
      pulse_d = 1'b0;
      case (st_q)
        IDLE: if (s) begin st_d = PRESS_WAIT; cnt_d = ONE; end
        PRESS_WAIT:
          if (!s) begin st_d = IDLE; cnt_d = '0; end
          else if (cnt_q + ONE == LAST) begin st_d = PRESSED; cnt_d = '0; pulse_d = 1'b1; end
          else cnt_d = cnt_q + ONE;
        PRESSED: if (!s) begin st_d = REL_WAIT; cnt_d = ONE; end
        REL_WAIT:
          if (s) begin st_d = PRESSED; cnt_d = '0; end
          else if (cnt_q + ONE == LAST) begin st_d = IDLE; cnt_d = '0; end
          else cnt_d = cnt_q + ONE;
        default: begin st_d = IDLE; cnt_d = '0; end
      endcase
    end
    assign pulse[i] = pulse_q;
  end
  assign up_ok = pulse[0] & ~pulse[1] & (WRAP | (count_q != 4'hf));
  assign dn_ok = pulse[1] & ~pulse[0] & (WRAP | (count_q != 4'h0));
  always_comb begin
    count_d = !bus.en ? count_q : pulse[2] ? 4'h0 : up_ok ? count_q + 4'd1 : dn_ok ? count_q - 4'd1 : count_q;
    step_d = bus.en & (pulse[2] ? |count_q : (up_ok | dn_ok));
    wrap_d = bus.en & ~pulse[2] & ((up_ok & (count_q == 4'hf)) | (dn_ok & (count_q == 4'h0)));
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      count_q <= 4'h0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      count_q <= count_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  assign bus.count = count_q;
  assign bus.step = step_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_debounced_hex_counter.sv
// tb_debounced_hex_counter: scoreboard bench for wrapping and saturating counter instances
module tb_debounced_hex_counter;
  typedef struct packed {logic [3:0] c; logic w;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int errors = 0;
  int m[2];
  exp_t q0[$];
  exp_t q1[$];
  always #5 clk = ~clk;
  debounced_hex_counter_if b0();
  debounced_hex_counter_if b1();
  debounced_hex_counter #(.DEBOUNCE_CYCLES(4), .WRAP(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  debounced_hex_counter #(.DEBOUNCE_CYCLES(4), .WRAP(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  always @(negedge clk)
    if (rst_n && b0.step) begin
      exp_t e;
      vectors++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL step0_unexpected count=%0d wrap=%0d required no step", b0.count, b0.wrap);
      end else begin
        e = q0.pop_front();
        if ({b0.count, b0.wrap} !== e) begin
          errors++;
          $display("FAIL step0 count=%0d wrap=%0d required count=%0d wrap=%0d", b0.count, b0.wrap, e.c, e.w);
        end
      end
    end
  always @(negedge clk)
    if (rst_n && (b1.step || b1.wrap)) begin
      exp_t e;
      vectors++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL step1_unexpected count=%0d wrap=%0d required no step", b1.count, b1.wrap);
      end else begin
        e = q1.pop_front();
        if ({b1.count, b1.wrap} !== e) begin
          errors++;
          $display("FAIL step1 count=%0d wrap=%0d required count=%0d wrap=%0d", b1.count, b1.wrap, e.c, e.w);
        end
      end
    end
  task automatic set_btns(input int d, input logic u, input logic dn, input logic c);
    if (d == 0) begin b0.btn_up = u; b0.btn_down = dn; b0.btn_clr = c; end
    else begin b1.btn_up = u; b1.btn_down = dn; b1.btn_clr = c; end
  endtask
  task automatic press(input int d, input logic u, input logic dn, input logic c, input int n);
    logic en_v;
    logic s;
    int cur, nx;
    logic [3:0] got;
    exp_t e;
    en_v = (d == 0) ? b0.en : b1.en;
    cur = m[d];
    nx = cur;
    s = 1'b0;
    e.w = 1'b0;
    if (en_v) begin
      if (c) begin nx = 0; s = (cur != 0); end
      else if (u && !dn) begin
        if (cur != 15) begin nx = cur + 1; s = 1'b1; end
        else if (d == 0) begin nx = 0; s = 1'b1; e.w = 1'b1; end
      end else if (dn && !u) begin
        if (cur != 0) begin nx = cur - 1; s = 1'b1; end
        else if (d == 0) begin nx = 15; s = 1'b1; e.w = 1'b1; end
      end
    end
    e.c = nx[3:0];
    if (s) begin
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    m[d] = nx;
    @(posedge clk); #1 set_btns(d, u, dn, c);
    repeat (n) @(posedge clk);
    #1 set_btns(d, 1'b0, 1'b0, 1'b0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    got = (d == 0) ? b0.count : b1.count;
    vectors++;
    if (got !== nx[3:0]) begin
      errors++;
      $display("FAIL press_count dut=%0d count=%0d required %0d", d, got, nx);
    end
    vectors++;
    if (((d == 0) ? q0.size() : q1.size()) != 0) begin
      errors++;
      $display("FAIL press_step_missing dut=%0d pending=%0d required 0", d, (d == 0) ? q0.size() : q1.size());
      if (d == 0) q0.delete(); else q1.delete();
    end
  endtask
  task automatic test_reset;
    b0.en = 1'b1;
    b1.en = 1'b1;
    set_btns(0, 1'b1, 1'b1, 1'b1);
    set_btns(1, 1'b1, 1'b1, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({b0.count, b0.step, b0.wrap} !== 6'b0) begin
      errors++;
      $display("FAIL reset0 count=%0d step=%0d wrap=%0d required 0 0 0", b0.count, b0.step, b0.wrap);
    end
    vectors++;
    if ({b1.count, b1.step, b1.wrap} !== 6'b0) begin
      errors++;
      $display("FAIL reset1 count=%0d step=%0d wrap=%0d required 0 0 0", b1.count, b1.step, b1.wrap);
    end
    set_btns(0, 1'b1, 1'b0, 1'b0);
    set_btns(1, 1'b0, 1'b0, 1'b0);
    m[0] = 1;
    m[1] = 0;
    q0.push_back('{c: 4'd1, w: 1'b0});
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (b0.count !== 4'd0) begin
      errors++;
      $display("FAIL reset_held_early count=%0d required 0", b0.count);
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (b0.count !== 4'd1 || b0.step !== 1'b1) begin
      errors++;
      $display("FAIL reset_held_step count=%0d step=%0d required 1 1", b0.count, b0.step);
    end
    #1 set_btns(0, 1'b0, 1'b0, 1'b0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (b0.count !== 4'd1 || q0.size() != 0) begin
      errors++;
      $display("FAIL reset_held_once count=%0d pending=%0d required 1 0", b0.count, q0.size());
    end
  endtask
  task automatic test_latency;
    press(0, 1'b1, 1'b0, 1'b0, 8);
    press(0, 1'b1, 1'b0, 1'b0, 8);
    m[0] = 4;
    q0.push_back('{c: 4'd4, w: 1'b0});
    @(posedge clk); #1 b0.btn_up = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (b0.count !== 4'd3) begin
      errors++;
      $display("FAIL latency_early count=%0d required 3", b0.count);
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (b0.count !== 4'd4 || b0.step !== 1'b1) begin
      errors++;
      $display("FAIL latency_edge count=%0d step=%0d required 4 1", b0.count, b0.step);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (b0.count !== 4'd4 || b0.step !== 1'b0) begin
      errors++;
      $display("FAIL hold_no_repeat count=%0d step=%0d required 4 0", b0.count, b0.step);
    end
    #1 b0.btn_up = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (b0.count !== 4'd4 || q0.size() != 0) begin
      errors++;
      $display("FAIL latency_after count=%0d pending=%0d required 4 0", b0.count, q0.size());
    end
  endtask
  task automatic test_glitch;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      b0.btn_up = 1'b1;
      repeat (2) @(posedge clk);
      #1 b0.btn_up = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (b0.count !== 4'd4) begin
      errors++;
      $display("FAIL glitch count=%0d required 4", b0.count);
    end
  endtask
  task automatic test_wrap;
    press(0, 1'b0, 1'b0, 1'b1, 8);
    press(0, 1'b0, 1'b1, 1'b0, 8);
    press(0, 1'b1, 1'b0, 1'b0, 8);
    press(0, 1'b0, 1'b1, 1'b0, 8);
    press(1, 1'b0, 1'b1, 1'b0, 8);
    for (int i = 0; i < 15; i++) press(1, 1'b1, 1'b0, 1'b0, 7);
    press(1, 1'b1, 1'b0, 1'b0, 8);
  endtask
  task automatic test_priority;
    press(0, 1'b1, 1'b1, 1'b0, 8);
    press(0, 1'b0, 1'b0, 1'b1, 8);
    for (int i = 0; i < 9; i++) press(0, 1'b1, 1'b0, 1'b0, 7);
    press(0, 1'b1, 1'b0, 1'b1, 8);
  endtask
  task automatic test_enable;
    for (int i = 0; i < 5; i++) press(0, 1'b1, 1'b0, 1'b0, 7);
    b0.en = 1'b0;
    press(0, 1'b1, 1'b0, 1'b0, 8);
    b0.en = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (b0.count !== 4'd5) begin
      errors++;
      $display("FAIL enable_not_queued count=%0d required 5", b0.count);
    end
  endtask
  initial begin
    test_reset;
    test_latency;
    test_glitch;
    test_wrap;
    test_priority;
    test_enable;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
